// File: rtl/bp_be_issue_queue_pkg.sv
// Shared types, widths and helpers for the backend issue queue.
// Default widths describe the standard core configuration.
package bp_be_issue_queue_pkg;

    localparam int vaddr_width_gp               = 39;
    localparam int branch_metadata_fwd_width_gp = 25;
    localparam int instr_width_gp               = 32;

    localparam int issue_queue_depth_gp     = 8;
    localparam int issue_queue_ptr_width_gp = $clog2(issue_queue_depth_gp);

    // Predecoded packet: fetch PC, branch metadata forwarded from FE, raw instruction.
    function automatic int bp_be_issue_pkt_width(input int vaddr_width, input int bmeta_width);
        return vaddr_width + bmeta_width + instr_width_gp;
    endfunction

    // Queue pointer: slot index plus a wrap bit that tells full from empty.
    typedef struct packed {
        logic                                wrap;
        logic [issue_queue_ptr_width_gp-1:0] idx;
    } bp_be_issue_queue_ptr_s;

endpackage

// File: rtl/bp_be_issue_queue_ptr.sv
// Enqueue, issue and commit pointers of the issue queue.
// Also derives full, issue-valid and the occupancy/in-flight counts.
module bp_be_issue_queue_ptr
    import bp_be_issue_queue_pkg::*;
#(
    parameter  int depth_p      = issue_queue_depth_gp,
    localparam int ptr_width_lp = $clog2(depth_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    enq_fire,
    input  logic                    issue_yumi,
    input  logic                    cmt_v,
    input  logic                    roll,
    input  logic                    clr,
    output logic [ptr_width_lp-1:0] enq_idx,
    output logic [ptr_width_lp-1:0] rd_idx,
    output logic                    full,
    output logic                    issue_v,
    output logic [ptr_width_lp:0]   occ_cnt,
    output logic [ptr_width_lp:0]   issued_cnt
);

    typedef logic [ptr_width_lp:0] ptr_t;

    ptr_t enq_r, rd_r, cmt_r;
    ptr_t enq_n, rd_n, cmt_n;

    // Commit is applied first so that replay and flush land on the post-commit head.
    always_comb begin
        cmt_n = cmt_r + ptr_t'(cmt_v);
        enq_n = enq_r;
        rd_n  = rd_r;
        if (clr) begin
            enq_n = cmt_n;
            rd_n  = cmt_n;
        end else if (roll) begin
            rd_n  = cmt_n;
        end else begin
            rd_n  = rd_r + ptr_t'(issue_yumi);
            enq_n = enq_r + ptr_t'(enq_fire);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            enq_r <= '0;
            rd_r  <= '0;
            cmt_r <= '0;
        end else begin
            enq_r <= enq_n;
            rd_r  <= rd_n;
            cmt_r <= cmt_n;
        end
    end

    assign enq_idx    = enq_r[ptr_width_lp-1:0];
    assign rd_idx     = rd_r[ptr_width_lp-1:0];
    assign occ_cnt    = enq_r - cmt_r;
    assign issued_cnt = rd_r - cmt_r;
    assign issue_v    = (rd_r != enq_r);
    assign full       = (enq_r[ptr_width_lp-1:0] == cmt_r[ptr_width_lp-1:0])
                     && (enq_r[ptr_width_lp] != cmt_r[ptr_width_lp]);

endmodule

// File: rtl/bp_be_issue_queue.sv
// Buffer of predecoded issue packets between the FE queue and the BE scheduler,
// holding issued packets until commit so a cache miss can replay without refetch.
module bp_be_issue_queue
    import bp_be_issue_queue_pkg::*;
#(
    parameter  int depth_p      = issue_queue_depth_gp,
    parameter  int pkt_width_p  = bp_be_issue_pkt_width(vaddr_width_gp, branch_metadata_fwd_width_gp),
    localparam int ptr_width_lp = $clog2(depth_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enq_v_i,
    input  logic [pkt_width_p-1:0] enq_pkt_i,
    output logic                   enq_ready_o,
    output logic                   issue_v_o,
    output logic [pkt_width_p-1:0] issue_pkt_o,
    input  logic                   issue_yumi_i,
    input  logic                   cmt_v_i,
    input  logic                   roll_i,
    input  logic                   clr_i,
    output logic                   full_o,
    output logic [ptr_width_lp:0]  occ_cnt_o,
    output logic [ptr_width_lp:0]  issued_cnt_o
);

    logic [ptr_width_lp-1:0] enq_idx, rd_idx;
    logic                    enq_fire;
    logic [pkt_width_p-1:0]  mem [depth_p];

    // A replay or flush cycle refuses new packets; FE holds them for the next cycle.
    assign enq_ready_o = ~full_o & ~clr_i & ~roll_i;
    assign enq_fire    = enq_v_i & enq_ready_o;

    bp_be_issue_queue_ptr #(
        .depth_p (depth_p)
    ) ptrs (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enq_fire   (enq_fire),
        .issue_yumi (issue_yumi_i),
        .cmt_v      (cmt_v_i),
        .roll       (roll_i),
        .clr        (clr_i),
        .enq_idx    (enq_idx),
        .rd_idx     (rd_idx),
        .full       (full_o),
        .issue_v    (issue_v_o),
        .occ_cnt    (occ_cnt_o),
        .issued_cnt (issued_cnt_o)
    );

    // Storage is deliberately not reset; pointers alone define which slots are live.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem[enq_idx] <= enq_pkt_i;
        end
    end

    assign issue_pkt_o = mem[rd_idx];

    assert property (@(posedge clk_i) disable iff (reset_i) issue_yumi_i |-> issue_v_o);
    assert property (@(posedge clk_i) disable iff (reset_i) cmt_v_i |-> (issued_cnt_o != '0));
    assert property (@(posedge clk_i) disable iff (reset_i) enq_v_i |-> !$isunknown(enq_pkt_i));
    assert property (@(posedge clk_i) disable iff (reset_i)
                     (occ_cnt_o <= (ptr_width_lp+1)'(depth_p)) && (issued_cnt_o <= occ_cnt_o));

endmodule

// File: tb/tb_bp_be_issue_queue.sv
// Scoreboard bench for the issue queue: a depth-8 instance for fill/stream/roll/clear/reset
// and a depth-4 instance for pointer wrap-around.
module tb_bp_be_issue_queue;

    localparam int pkt_w = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    logic             enq_v, enq_ready, issue_v, issue_yumi, cmt_v, roll, clr, full;
    logic [pkt_w-1:0] enq_pkt, issue_pkt;
    logic [3:0]       occ_cnt, issued_cnt;

    logic             enq_v_w, enq_ready_w, issue_v_w, issue_yumi_w, cmt_v_w, roll_w, clr_w, full_w;
    logic [pkt_w-1:0] enq_pkt_w, issue_pkt_w;
    logic [2:0]       occ_cnt_w, issued_cnt_w;

    int checks = 0;
    int errors = 0;

    logic [pkt_w-1:0] exp_q   [$];
    logic [pkt_w-1:0] exp_q_w [$];

    bp_be_issue_queue #(.depth_p(8), .pkt_width_p(pkt_w)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .enq_v_i      (enq_v),
        .enq_pkt_i    (enq_pkt),
        .enq_ready_o  (enq_ready),
        .issue_v_o    (issue_v),
        .issue_pkt_o  (issue_pkt),
        .issue_yumi_i (issue_yumi),
        .cmt_v_i      (cmt_v),
        .roll_i       (roll),
        .clr_i        (clr),
        .full_o       (full),
        .occ_cnt_o    (occ_cnt),
        .issued_cnt_o (issued_cnt)
    );

    bp_be_issue_queue #(.depth_p(4), .pkt_width_p(pkt_w)) dut_wrap (
        .clk_i        (clk),
        .reset_i      (reset),
        .enq_v_i      (enq_v_w),
        .enq_pkt_i    (enq_pkt_w),
        .enq_ready_o  (enq_ready_w),
        .issue_v_o    (issue_v_w),
        .issue_pkt_o  (issue_pkt_w),
        .issue_yumi_i (issue_yumi_w),
        .cmt_v_i      (cmt_v_w),
        .roll_i       (roll_w),
        .clr_i        (clr_w),
        .full_o       (full_w),
        .occ_cnt_o    (occ_cnt_w),
        .issued_cnt_o (issued_cnt_w)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h expected 'h%0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus for the selected instance; an issue pushes its expected packet.
    task automatic applyStimulus(input bit to_wrap, input bit ev, input int pkt, input bit y,
                                 input int exp_pkt, input bit c, input bit r, input bit cl);
        @(posedge clk);
        #1;
        enq_v   = 1'b0; enq_pkt   = '0; issue_yumi   = 1'b0; cmt_v   = 1'b0; roll   = 1'b0; clr   = 1'b0;
        enq_v_w = 1'b0; enq_pkt_w = '0; issue_yumi_w = 1'b0; cmt_v_w = 1'b0; roll_w = 1'b0; clr_w = 1'b0;
        if (to_wrap) begin
            enq_v_w = ev; enq_pkt_w = pkt_w'(pkt); issue_yumi_w = y; cmt_v_w = c; roll_w = r; clr_w = cl;
            if (y) exp_q_w.push_back(pkt_w'(exp_pkt));
        end else begin
            enq_v = ev; enq_pkt = pkt_w'(pkt); issue_yumi = y; cmt_v = c; roll = r; clr = cl;
            if (y) exp_q.push_back(pkt_w'(exp_pkt));
        end
    endtask

    task automatic settle();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    // Monitors: every accepted issue is matched against the oldest expected packet.
    always @(negedge clk) begin
        if (!reset && issue_yumi) begin
            checkOutput("issueValid", int'(issue_v), 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL issuePkt: got 'h%0h with no packet expected", issue_pkt);
            end else begin
                checkOutput("issuePkt", int'(issue_pkt), int'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && issue_yumi_w) begin
            checkOutput("wrapIssueValid", int'(issue_v_w), 1);
            if (exp_q_w.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL wrapIssuePkt: got 'h%0h with no packet expected", issue_pkt_w);
            end else begin
                checkOutput("wrapIssuePkt", int'(issue_pkt_w), int'(exp_q_w.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        enq_v   = 1'b0; enq_pkt   = '0; issue_yumi   = 1'b0; cmt_v   = 1'b0; roll   = 1'b0; clr   = 1'b0;
        enq_v_w = 1'b0; enq_pkt_w = '0; issue_yumi_w = 1'b0; cmt_v_w = 1'b0; roll_w = 1'b0; clr_w = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rstIssueV",   int'(issue_v),    0);
        checkOutput("rstFull",     int'(full),       0);
        checkOutput("rstReady",    int'(enq_ready),  1);
        checkOutput("rstOcc",      int'(occ_cnt),    0);
        checkOutput("rstIssued",   int'(issued_cnt), 0);
        checkOutput("rstWrapOcc",  int'(occ_cnt_w),  0);
        checkOutput("rstWrapIss",  int'(issued_cnt_w), 0);
        checkOutput("rstWrapFull", int'(full_w),     0);

        $display("[TB] fill test");
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 'hA000 + i, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 'hBEEF, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fillFull",  int'(full),      1);
        checkOutput("fillReady", int'(enq_ready), 0);
        checkOutput("fillOcc",   int'(occ_cnt),   8);
        settle();
        checkOutput("fillDropOcc", int'(occ_cnt), 8);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 0, 1'b1, 'hA000 + i, i > 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("drainOcc",    int'(occ_cnt),    0);
        checkOutput("drainIssueV", int'(issue_v),    0);
        checkOutput("drainIssued", int'(issued_cnt), 0);

        $display("[TB] stream test");
        applyStimulus(1'b0, 1'b1, 'hC000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("noBypass", int'(issue_v), 0);
        for (int i = 1; i < 4; i++) applyStimulus(1'b0, 1'b1, 'hC000 + i, 1'b1, 'hC000 + i - 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 'hC003, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("streamIssued", int'(issued_cnt), 4);
        checkOutput("streamOcc",    int'(occ_cnt),    4);
        checkOutput("streamIssueV", int'(issue_v),    0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("streamCmtIssued", int'(issued_cnt), 0);
        checkOutput("streamCmtOcc",    int'(occ_cnt),    0);

        $display("[TB] roll test");
        applyStimulus(1'b0, 1'b1, 'hD00A, 1'b0, 0,       1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 'hD00B, 1'b1, 'hD00A, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 'hD00C, 1'b1, 'hD00B, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0,      1'b1, 'hD00C, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0,      1'b0, 0,       1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 'hDEAD, 1'b0, 0,       1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("rollReady", int'(enq_ready), 0);
        settle();
        checkOutput("rollPkt",    int'(issue_pkt),  'hD00B);
        checkOutput("rollIssueV", int'(issue_v),    1);
        checkOutput("rollIssued", int'(issued_cnt), 0);
        checkOutput("rollOcc",    int'(occ_cnt),    2);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 'hD00B, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 'hD00C, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 0,       1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("rollDrainOcc", int'(occ_cnt), 0);

        $display("[TB] clear test");
        applyStimulus(1'b0, 1'b1, 'hE000, 1'b0, 0,       1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 'hE001, 1'b1, 'hE000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 'hE002, 1'b1, 'hE001, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 'hE003, 1'b0, 0,       1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 'hE004, 1'b0, 0,       1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("clrPreOcc",    int'(occ_cnt),    5);
        checkOutput("clrPreIssued", int'(issued_cnt), 2);
        applyStimulus(1'b0, 1'b1, 'hDEAD, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("clrReady", int'(enq_ready), 0);
        settle();
        checkOutput("clrOcc",    int'(occ_cnt),    0);
        checkOutput("clrIssueV", int'(issue_v),    0);
        checkOutput("clrIssued", int'(issued_cnt), 0);

        $display("[TB] reset test");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 'hF000 + i, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("midRstPreOcc", int'(occ_cnt), 3);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("midRstIssueV", int'(issue_v),    0);
        checkOutput("midRstOcc",    int'(occ_cnt),    0);
        checkOutput("midRstReady",  int'(enq_ready),  1);
        checkOutput("midRstIssued", int'(issued_cnt), 0);

        $display("[TB] wrap test");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 'h5000 + i, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("wrap3Full", int'(full_w),    0);
        checkOutput("wrap3Occ",  int'(occ_cnt_w), 3);
        applyStimulus(1'b1, 1'b1, 'h5003, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        settle();
        checkOutput("wrap4Full",  int'(full_w),      1);
        checkOutput("wrap4Occ",   int'(occ_cnt_w),   4);
        checkOutput("wrap4Ready", int'(enq_ready_w), 0);
        applyStimulus(1'b1, 1'b0, 0, 1'b1, 'h5000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b1, 'h5001, 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 20; j++) begin
            applyStimulus(1'b1, 1'b1, 'h5004 + j, 1'b1, 'h5002 + j, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            checkOutput("wrapStreamFull", int'(full_w),    0);
            checkOutput("wrapStreamOcc",  int'(occ_cnt_w), 3);
        end
        applyStimulus(1'b1, 1'b0, 0, 1'b1, 'h5016, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b1, 'h5017, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 0,       1'b1, 1'b0, 1'b0);
        settle();
        checkOutput("wrapDrainOcc",    int'(occ_cnt_w),    0);
        checkOutput("wrapDrainIssueV", int'(issue_v_w),    0);
        checkOutput("wrapDrainIssued", int'(issued_cnt_w), 0);

        checkOutput("scoreboardEmpty",     exp_q.size(),   0);
        checkOutput("wrapScoreboardEmpty", exp_q_w.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
